// File: rtl/conv2_window_gen.sv
// ---------------------------------------------------------------------------
// conv2_window_gen
//
// Streaming 3x3 sliding-window generator that feeds the conv2 depthwise
// stage. Pixels arrive in raster order, one per accepted beat, each carrying
// CH channels of AW-bit signed activations. The activations are only moved
// and never modified. The two previous image rows are held in line buffers.
// A complete 3x3xCH window is presented one cycle after the pixel that
// completes it.
//
// Configuration macro:
//   CONV2_WIN_STRIDE2_EN - when defined, windows are emitted with stride 2.
//                          The default build uses stride 1.
//
// Ports:
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   frame_rst  - synchronous frame restart; clears the position counters
//   in_valid   - a pixel beat is present this cycle
//   in_pixel   - pixel; channel c at [c*AW +: AW]
//   out_valid  - window valid; drives the depthwise valid input
//   out_act    - window; channel c, tap k at [(c*9+k)*AW +: AW]
//                k = ky*3+kx, ky=0 is the oldest row, kx=0 the leftmost column
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module conv2_window_gen #(
    parameter int CH    = 8,
    parameter int AW    = 16,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 frame_rst,
    input  logic                 in_valid,
    input  logic [CH*AW-1:0]     in_pixel,
    output logic                 out_valid,
    output logic [CH*9*AW-1:0]   out_act,
    output logic                 frame_done
);

    localparam int PW = CH * AW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [PW-1:0]      lb0 [IMG_W];
    logic [PW-1:0]      lb1 [IMG_W];
    logic [PW-1:0]      win [3][3];

    logic [CW-1:0]      pos_col;
    logic [RW-1:0]      pos_row;
    logic [PW-1:0]      win_next [3][3];
    logic               emit;
    logic               last_pix;
    logic [CH*9*AW-1:0] act_next;

    // A frame restart applies to the beat arriving in the same cycle. That
    // pixel is placed at (0,0), so the effective position is forced to zero
    // before it is used.
    always_comb begin
        pos_col  = frame_rst ? '0 : col;
        pos_row  = frame_rst ? '0 : row;

        for (int ky = 0; ky < 3; ky++) begin
            win_next[ky][0] = win[ky][1];
            win_next[ky][1] = win[ky][2];
        end
        win_next[0][2] = lb0[pos_col];
        win_next[1][2] = lb1[pos_col];
        win_next[2][2] = in_pixel;

`ifdef CONV2_WIN_STRIDE2_EN
        // (row-2) and (col-2) are even exactly when row and col are even.
        emit = in_valid && (pos_row >= RW'(2)) && (pos_col >= CW'(2)) &&
               !pos_row[0] && !pos_col[0];
`else
        emit = in_valid && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
`endif

        last_pix = in_valid && (pos_row == RW'(IMG_H - 1)) &&
                   (pos_col == CW'(IMG_W - 1));

        act_next = '0;
        for (int c = 0; c < CH; c++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    act_next[(c*9 + ky*3 + kx)*AW +: AW] = win_next[ky][kx][c*AW +: AW];
                end
            end
        end
    end

    // Raster position counters. The column wraps at the end of each row, and
    // the row wraps at the end of the frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (pos_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end else if (frame_rst) begin
            col <= '0;
            row <= '0;
        end
    end

    // Line buffers shift vertically at the current column. lb1 holds row-1
    // and lb0 holds row-2. A frame restart leaves them untouched, because
    // rows 0 and 1 of the new frame are rewritten before any window uses them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else if (in_valid) begin
            lb0[pos_col] <= lb1[pos_col];
            lb1[pos_col] <= in_pixel;
        end
    end

    // The 3x3 window moves left by one column for each accepted pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    win[ky][kx] <= win_next[ky][kx];
                end
            end
        end
    end

    // The output window is loaded only when a window is emitted. It holds its
    // value between pulses, because the window registers keep changing on
    // beats that do not emit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_act    <= '0;
        end else begin
            out_valid  <= emit;
            frame_done <= last_pix;
            if (emit) begin
                out_act <= act_next;
            end
        end
    end

endmodule

// File: doc/conv2_window_gen.md
Name: conv2_window_gen

Overview:
- Streaming 3x3 sliding-window generator directly upstream of the conv2 depthwise stage.
- Accepts one pixel per beat in raster order: CH channels x AW-bit activations.
- Buffers the two previous image rows and emits one full 3x3xCH window per valid output position, stride 1, no padding.
- Output bus layout and valid pulse drive the depthwise stage's valid/input_act inputs directly.

Parameters:
- CH, 8, channels per pixel
- AW, 16, activation width in bits (signed, passed through untouched)
- IMG_W, 16, image width in pixels (>=3)
- IMG_H, 16, image height in pixels (>=3)

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- frame_rst  input  1  synchronous frame restart; clears position counters
- in_valid  input  1  pixel beat present this cycle
- in_pixel  input  CH*AW  pixel; channel c at [c*AW +: AW]
- out_valid  output  1  window valid; connects to depthwise valid
- out_act  output  CH*9*AW  window; channel c, tap k at [(c*9+k)*AW +: AW]
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset values:
  - out_valid=0, out_act=0, frame_done=0.
  - Column counter col=0, row counter row=0.
  - Window registers and line buffers=0.
- No backpressure:
  - Every cycle with in_valid=1 accepts a pixel.
  - in_valid=0 changes no state; out_valid and frame_done are 0 that cycle.
- Accepted pixel at position (row,col):
  - Line buffer 1 (row-1) and line buffer 0 (row-2) shift at column col; buffer depth IMG_W entries of CH*AW bits.
  - 3x3 window shift register shifts left one column; the new right column is {lb0[col], lb1[col], in_pixel}, top to bottom.
  - Counters: col increments; at col==IMG_W-1, col wraps to 0 and row increments.
  - At row==IMG_H-1 and col==IMG_W-1, row wraps to 0 and frame_done pulses next cycle.
- Window emission:
  - If row>=2 and col>=2 at acceptance, out_valid=1 on the next cycle with the completed window in out_act (latency 1 cycle from the completing pixel).
  - Tap index k = ky*3+kx. ky=0 is the oldest row (row-2); kx=0 is the leftmost column (col-2). Tap 4 is the centre; tap 8 is the just-accepted pixel.
- Hold behaviour: out_act holds its last value while out_valid=0. The downstream stage samples only on valid.
- Window count per frame: (IMG_W-2)*(IMG_H-2).
- Row wrap: columns 0 and 1 of each row never emit. Window registers holding stale previous-row data at those positions is legal because they are never output.
- frame_rst=1:
  - Sets col=0 and row=0 next cycle; clears out_valid and frame_done next cycle.
  - Line buffers are not cleared; stale contents are never emitted because rows 0-1 are refilled first.
- Simultaneous frame_rst and in_valid: frame_rst wins, and the pixel is accepted as position (0,0) of the new frame (counters then read col=1, row=0).
- rstn asserted mid-frame: all state returns to reset values immediately. The first beat after release is (0,0).
- Width rules: pure data movement, no arithmetic on activations. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits.

Optional Feature:
- Macro: CONV2_WIN_STRIDE2_EN.
- Defined: stride 2. A window is emitted only when row>=2, col>=2, (row-2) even and (col-2) even at acceptance. Window count = floor((IMG_W-1)/2)*floor((IMG_H-1)/2). Buffering, latency and frame_done are unchanged.
- Undefined: stride 1 as above.

Test Plan:
- IMG_W=4, IMG_H=4. Stream 16 pixels back-to-back; lane c of pixel n = 256*c+n.
  - Expect exactly 4 out_valid pulses, 1 cycle after pixels 10, 11, 14, 15.
  - First window channel 0 taps k0..k8 = 0,1,2,4,5,6,8,9,10; channel 3 = 768+ those values.
  - frame_done pulses once, 1 cycle after pixel 15.
- Same frame with in_valid toggled 1,0,1,0 → identical windows and ordering; out_valid never asserted in an idle-following cycle without an accepting pixel; out_act held between pulses.
- Two frames back-to-back without gaps → 8 windows. The second frame's first window uses only second-frame pixels (taps 16..26 pattern: 16,17,18,20,21,22,24,25,26).
- frame_rst asserted together with pixel 7 of frame 1, then 15 more pixels → that pixel is treated as (0,0); windows match a fresh frame starting at it; exactly 4 windows after restart.
- rstn pulsed low mid-frame (after pixel 9) → out_valid/out_act/frame_done read 0 immediately; a following full frame gives 4 correct windows.
- CONV2_WIN_STRIDE2_EN defined, IMG_W=5, IMG_H=5 → 4 windows, after pixels at (2,2),(2,4),(4,2),(4,4) = indices 12, 14, 22, 24; first window channel 0 = 0,1,2,5,6,7,10,11,12.
